// File: rtl/jk_pkg.sv
// Shared encodings and JK next-state helper for the JK flip-flop stimulus sequencer.
package jk_pkg;

    typedef enum logic [1:0] {
        JK_HOLD = 2'b00,
        JK_RST  = 2'b01,
        JK_SET  = 2'b10,
        JK_TOG  = 2'b11
    } jk_op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_DRIVE = 2'b01,
        S_DRAIN = 2'b10
    } jk_state_e;

    function automatic logic jk_next(input logic q, input logic j, input logic k);
        logic r;
        case ({j, k})
            2'b10:   r = 1'b1;
            2'b01:   r = 1'b0;
            2'b11:   r = ~q;
            default: r = q;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/jk_sequencer.sv
// Drives a JK flip-flop's j/k for a commanded number of cycles and checks its q
// against an internal reference model, raising a sticky error on mismatch.
module jk_sequencer
    import jk_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_len,
    output logic             j,
    output logic             k,
    input  logic             q_in,
    output logic             exp_q,
    output logic             busy,
    output logic             done,
    input  logic             clr_err,
    output logic             err
);

    jk_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             j_q, j_d;
    logic             k_q, k_d;
    logic             exp_q_q;
    logic             err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            j_q     <= 1'b0;
            k_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            j_q     <= j_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        j_d     = j_q;
        k_d     = k_q;
        case (state_q)
            S_IDLE: begin
                j_d = 1'b0;
                k_d = 1'b0;
                if (cmd_valid) begin
                    state_d    = S_DRIVE;
                    cnt_d      = cmd_len;
                    {j_d, k_d} = cmd_op;
                end
            end
            S_DRIVE: begin
                // The last drive cycle is the one seen with cnt at zero.
                if (cnt_q == '0) begin
                    j_d     = 1'b0;
                    k_d     = 1'b0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DRAIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                j_d     = 1'b0;
                k_d     = 1'b0;
            end
        endcase
    end

    // Model advances on the same registered j/k the flip-flop samples, so no skew.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_q_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            exp_q_q <= jk_next(exp_q_q, j_q, k_q);
            if (q_in != exp_q_q) begin
                err_q <= 1'b1;
            end else if (clr_err) begin
                err_q <= 1'b0;
            end
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DRAIN);
    assign j         = j_q;
    assign k         = k_q;
    assign exp_q     = exp_q_q;
    assign err       = err_q;

endmodule

// File: tb/tb_jk_sequencer.sv
// Directed bench for jk_sequencer driving a behavioural JK flip-flop, with a
// scoreboard of expected final q per command popped at each done pulse.
module tb_jk_sequencer;
    import jk_pkg::*;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             cmd_valid = 1'b0;
    logic [1:0]       cmd_op = 2'b00;
    logic [CNT_W-1:0] cmd_len = '0;
    logic             clr_err = 1'b0;
    logic             force_en = 1'b0;
    logic             force_val = 1'b0;
    logic             cmd_ready, j, k, exp_q, busy, done, err;
    logic             q_in, ff_q;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string tag;
        logic  q;
    } sb_t;
    sb_t  sb[$];
    logic model_q = 1'b0;

    always #5 clk = ~clk;

    // Lab JK flip-flop; its active-high reset is the inverse of the sequencer reset.
    always_ff @(posedge clk or posedge (~reset)) begin
        if (~reset) ff_q <= 1'b0;
        else begin
            case ({j, k})
                2'b10:   ff_q <= 1'b1;
                2'b01:   ff_q <= 1'b0;
                2'b11:   ff_q <= ~ff_q;
                default: ff_q <= ff_q;
            endcase
        end
    end

    assign q_in = force_en ? force_val : ff_q;

    jk_sequencer #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .j(j), .k(k), .q_in(q_in),
        .exp_q(exp_q), .busy(busy), .done(done), .clr_err(clr_err), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic final_q(input logic [1:0] op, input int len, input logic q0);
        case (op)
            JK_RST:  return 1'b0;
            JK_SET:  return 1'b1;
            JK_TOG:  return q0 ^ logic'((len + 1) % 2);
            default: return q0;
        endcase
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_ready"}, cmd_ready, 1);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_done"},  done, 0);
        chk({tag, "_jk"},    {j, k}, 0);
    endtask

    task automatic pop_check(input string tag);
        sb_t e;
        chk({tag, "_sb_nonempty"}, sb.size() > 0, 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.tag, "_exp_q"}, exp_q, e.q);
            chk({e.tag, "_q_in"},  q_in,  e.q);
            $display("txn %s: done, final q=%0b exp_q=%0b", e.tag, q_in, exp_q);
        end
    endtask

    // Issue one command from a negedge and follow it through to idle.
    task automatic send_cmd(input logic [1:0] op, input int len, input string tag);
        chk({tag, "_ready_pre"}, cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = CNT_W'(len);
        sb.push_back('{tag, final_q(op, len, model_q)});
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            chk($sformatf("%s_drv%0d_busy", tag, i), {busy, cmd_ready, done}, 3'b100);
            chk($sformatf("%s_drv%0d_jk", tag, i), {j, k}, op);
            chk($sformatf("%s_drv%0d_q", tag, i), {exp_q, q_in}, {model_q, model_q});
            model_q = jk_next(model_q, op[1], op[0]);
            @(negedge clk);
        end
        chk({tag, "_drain_done"}, {done, busy, cmd_ready}, 3'b110);
        chk({tag, "_drain_jk"}, {j, k}, 0);
        pop_check(tag);
        @(negedge clk);
        check_idle({tag, "_after"});
    endtask

    initial begin
        // Reset held for two cycles
        @(negedge clk);
        @(negedge clk);
        check_idle("rst");
        chk("rst_err", err, 0);
        chk("rst_exp_q", exp_q, 0);
        reset = 1'b1;
        @(negedge clk);
        check_idle("post_rst");
        chk("post_rst_err", err, 0);
        chk("post_rst_exp_q", exp_q, 0);

        send_cmd(JK_SET, 2, "set_len2");
        chk("set_err", err, 0);
        send_cmd(JK_TOG, 3, "tog_len3");
        chk("tog_final_q", q_in, 1);
        chk("tog_err", err, 0);
        send_cmd(JK_HOLD, 15, "hold_max");
        chk("hold_err", err, 0);

        // Back-to-back with cmd_valid held high
        cmd_valid = 1'b1; cmd_op = JK_RST; cmd_len = CNT_W'(1);
        sb.push_back('{"b2b_rst", 1'b0});
        @(negedge clk);
        chk("b2b_rst_jk", {j, k}, 2'b01);
        chk("b2b_ignored_ready", cmd_ready, 0);
        @(negedge clk);
        @(negedge clk);
        chk("b2b_rst_done", {done, cmd_ready}, 2'b10);
        pop_check("b2b_rst");
        cmd_op = JK_SET; cmd_len = CNT_W'(0);
        sb.push_back('{"b2b_set", 1'b1});
        @(negedge clk);
        chk("b2b_gap_idle", {cmd_ready, busy, done}, 3'b100);
        @(negedge clk);
        chk("b2b_set_accepted", {busy, j, k}, 3'b110);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("b2b_set_done", done, 1);
        pop_check("b2b_set");
        @(negedge clk);
        check_idle("b2b_after");
        model_q = 1'b1;

        // Sticky error from a forced mismatch during SET
        cmd_valid = 1'b1; cmd_op = JK_SET; cmd_len = CNT_W'(3);
        sb.push_back('{"err_set", 1'b1});
        @(negedge clk);
        cmd_valid = 1'b0;
        force_en = 1'b1; force_val = 1'b0;
        chk("err_before", err, 0);
        @(negedge clk);
        chk("err_rise", err, 1);
        force_en = 1'b0;
        @(negedge clk);
        chk("err_sticky", err, 1);
        @(negedge clk);
        @(negedge clk);
        chk("err_set_done", done, 1);
        pop_check("err_set");
        @(negedge clk);
        check_idle("err_after");
        force_en = 1'b1; clr_err = 1'b1;
        @(negedge clk);
        chk("clr_vs_mismatch", err, 1);
        force_en = 1'b0;
        @(negedge clk);
        chk("clr_err", err, 0);
        clr_err = 1'b0;
        @(negedge clk);
        chk("clr_err_hold", err, 0);

        // Reset mid-DRIVE abandons the command
        cmd_valid = 1'b1; cmd_op = JK_TOG; cmd_len = CNT_W'(7);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_busy_pre", busy, 1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_jk", {j, k}, 0);
        chk("mid_rst_flags", {busy, cmd_ready, done}, 3'b010);
        chk("mid_rst_exp_q", exp_q, 0);
        chk("mid_rst_q_in", q_in, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("mid_rst_nodone%0d", i), done, 0);
        end
        reset = 1'b1;
        model_q = 1'b0;
        @(negedge clk);
        check_idle("mid_release");
        chk("mid_release_err", err, 0);
        send_cmd(JK_SET, 0, "post_mid_set");
        chk("post_mid_err", err, 0);
        chk("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/jk_sequencer.md
# jk_sequencer

Command-driven stimulus stage that sits directly upstream of the lab JK flip-flop. It accepts hold/reset/set/toggle commands over a valid/ready handshake and drives the flip-flop's `j`/`k` inputs for a programmed number of cycles. It keeps a reference model of the expected `q`, compares it against the flip-flop's actual output, and flags any mismatch. Integration: the flip-flop's active-high reset is driven by `~reset` from this block's reset.

## Interface
- `CNT_W`, default 4: width of the repeat-length field.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_op`  in  2  operation:
  - 00 HOLD: j=0, k=0.
  - 01 RST: j=0, k=1.
  - 10 SET: j=1, k=0.
  - 11 TOG: j=1, k=1.
- `cmd_len`  in  CNT_W  `j`/`k` are applied for `cmd_len+1` cycles.
- `j`, `k`  out  1  registered drive to the flip-flop.
- `q_in`  in  1  flip-flop `q`.
- `exp_q`  out  1  model of the expected `q`.
- `busy`  out  1  high when state is not IDLE.
- `done`  out  1  one-cycle pulse at command completion.
- `clr_err`  in  1  clears `err`.
- `err`  out  1  sticky mismatch flag.

## Operation
- FSM states:
  - IDLE: `cmd_ready`=1 and `j`=`k`=0. When `cmd_valid`&&`cmd_ready` is high at an edge, latch `cmd_op`, load `cnt`←`cmd_len`, register `j`/`k` from the op, and go to DRIVE.
  - DRIVE: `j`/`k` held. Each edge: if `cnt`≠0, `cnt`←`cnt`−1; if `cnt`==0, `j`=`k`←0 and go to DRAIN.
  - DRAIN: `done`=1 for exactly this cycle; the next edge goes to IDLE.
- `cmd_ready` is low in DRIVE and DRAIN. `cmd_valid` in those states is ignored, not queued.
- Model update, every edge: `exp_q` ← `j&~k` ? 1 : `~j&k` ? 0 : `j&k` ? `~exp_q` : `exp_q`. It uses the same registered `j`/`k` the flip-flop samples.
- Check, every edge out of reset: if `q_in`≠`exp_q`, `err`←1. Otherwise, if `clr_err`=1, `err`←0. A mismatch in the same cycle as `clr_err` wins, so `err` stays 1.
- `cnt` is an unsigned CNT_W-bit counter. `cmd_len` = 2^CNT_W−1 gives the maximum of 2^CNT_W drive cycles. There is no wrap: `cnt` never decrements below 0.
- Reset values, applied asynchronously the moment `reset`=0:
  - state = IDLE
  - `j`=`k`=0
  - `cnt`=0
  - `exp_q`=0
  - `err`=0
  - `done`=0
  - `busy`=0
  - `cmd_ready`=1
- Reset mid-operation abandons the command. No `done` is produced for it.

## Timing
- Accept edge t0 → `j`/`k` valid in cycles t0+1 … t0+1+`cmd_len`.
- `done` is high in cycle t0+2+`cmd_len`.
- `cmd_ready` is high again from t0+3+`cmd_len`. Back-to-back throughput is one command per `cmd_len`+3 cycles.
- `exp_q` and flip-flop `q` both change on the edge after `j`/`k` change, so the model matches the flip-flop with zero skew.
- `err` rises on the edge following the first mismatching cycle (1-cycle latency).

## Structure
- Shared package `jk_pkg` holds:
  - op encodings `JK_HOLD`, `JK_RST`, `JK_SET`, `JK_TOG`;
  - FSM state encodings `S_IDLE`, `S_DRIVE`, `S_DRAIN`;
  - function `jk_next(q, j, k)`, used by both RTL and bench.
- No sub-module. The model is a single register using `jk_next`. The top-level bench instantiates `jk_sequencer` with the JK flip-flop.

## Test plan
- Hold `reset`=0 for 2 cycles → `j`=`k`=0, `cmd_ready`=1, `busy`=0, `done`=0, `err`=0, `exp_q`=0. Release → all unchanged.
- SET, `cmd_len`=2 → `j`=1/`k`=0 for 3 cycles, then `done` for 1 cycle, then `cmd_ready`=1. `exp_q`=`q_in`=1 from the first drive edge. `err`=0.
- TOG, `cmd_len`=3 from `q`=1 → `q_in` sequence 0,1,0,1 across 4 edges, ends at 1. `exp_q` tracks it. `err`=0.
- `cmd_valid` held high with RST then SET → second command accepted exactly one cycle after the first `done`. Final `q`=1.
- Force `q_in`=0 during SET → `err`=1 one edge later and stays high after the force is released. `clr_err`=1 while matching → `err`=0.
- Assert `reset`=0 mid-DRIVE of TOG, `cmd_len`=7 → `j`=`k`=0, `busy`=0, `exp_q`=0 immediately, with no `done` pulse. A new command is accepted normally after release.
